// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit with in-order tag FIFO, 2-entry instruction queue and redirect flush
//
// Purpose: issues instruction-memory reads from a PC register, keeps at most two
// fetches in flight or buffered, presents fetched {pc,inst} to decode, and on a
// branch redirect flushes the queue and discards responses to stale requests.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    decode not accepting; hold the presented fetch
//   br, br_target            redirect request and new PC
//   im_req, im_addr          memory read request / address (= PC)
//   im_gnt                   memory accepts the request this cycle
//   im_rvalid, im_rdata      in-order read response
//   if_valid, if_pc, if_inst presented instruction (pc/inst forced to 0 when not valid)
//   stall_cnt, flush_cnt     performance counters, present only with FETCH_PERF_EN defined
//
// Configuration macro: FETCH_PERF_EN (adds stall_cnt/flush_cnt outputs).

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br,
  input  logic [31:0] br_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q [2];
  logic [31:0] tag_d [2];
  logic        tag_rd_q, tag_rd_d;
  logic [1:0]  tag_cnt_q, tag_cnt_d;
  logic [31:0] qpc_q [2];
  logic [31:0] qpc_d [2];
  logic [31:0] qinst_q [2];
  logic [31:0] qinst_d [2];
  logic        q_rd_q, q_rd_d;
  logic [1:0]  q_cnt_q, q_cnt_d;
  logic [1:0]  drop_q, drop_d;

  logic        rsp;
  logic        issue;
  logic        push;
  logic        pop;
  logic [1:0]  tag_left;
  logic        tag_wr_idx;
  logic        q_wr_idx;
  logic [2:0]  in_use;

  // Credit is taken from registered counts only; a response or pop this cycle
  // does not free a slot until the next cycle.
  assign in_use     = {1'b0, tag_cnt_q} + {1'b0, q_cnt_q};
  assign im_req     = !rst && !br && (in_use < 3'd2);
  assign im_addr    = pc_q;
  assign issue      = im_req && im_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp        = im_rvalid && (tag_cnt_q != 2'd0);
  assign tag_left   = tag_cnt_q - {1'b0, rsp};
  assign tag_wr_idx = tag_rd_q ^ tag_cnt_q[0];
  assign q_wr_idx   = q_rd_q ^ q_cnt_q[0];

  assign if_valid   = (q_cnt_q != 2'd0);
  assign if_pc      = if_valid ? qpc_q[q_rd_q] : 32'd0;
  assign if_inst    = if_valid ? qinst_q[q_rd_q] : 32'd0;

  always_comb begin
    pc_d      = pc_q;
    tag_d     = tag_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    qpc_d     = qpc_q;
    qinst_d   = qinst_q;
    q_rd_d    = q_rd_q;
    q_cnt_d   = q_cnt_q;
    drop_d    = drop_q;
    push      = 1'b0;
    pop       = 1'b0;

    // Tag FIFO tracks every issued address, including ones later dropped.
    if (rsp) begin
      tag_rd_d = ~tag_rd_q;
    end
    if (issue) begin
      tag_d[tag_wr_idx] = pc_q;
      pc_d              = pc_q + 32'd4;
    end
    tag_cnt_d = tag_cnt_q + {1'b0, issue} - {1'b0, rsp};

    if (br) begin
      // Redirect wins over stall; any same-cycle response is discarded and
      // everything still in flight after it must be dropped on return.
      pc_d    = br_target;
      q_cnt_d = 2'd0;
      drop_d  = tag_left;
    end else begin
      push = rsp && (drop_q == 2'd0);
      pop  = if_valid && !stall;
      if (rsp && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end
      // Credit guarantees the queue has room whenever a response arrives.
      if (push) begin
        qpc_d[q_wr_idx]   = tag_q[tag_rd_q];
        qinst_d[q_wr_idx] = im_rdata;
      end
      if (pop) begin
        q_rd_d = ~q_rd_q;
      end
      q_cnt_d = q_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag_q[0]   <= 32'd0;
      tag_q[1]   <= 32'd0;
      tag_rd_q   <= 1'b0;
      tag_cnt_q  <= 2'd0;
      qpc_q[0]   <= 32'd0;
      qpc_q[1]   <= 32'd0;
      qinst_q[0] <= 32'd0;
      qinst_q[1] <= 32'd0;
      q_rd_q     <= 1'b0;
      q_cnt_q    <= 2'd0;
      drop_q     <= 2'd0;
    end else begin
      pc_q      <= pc_d;
      tag_q     <= tag_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      qpc_q     <= qpc_d;
      qinst_q   <= qinst_d;
      q_rd_q    <= q_rd_d;
      q_cnt_q   <= q_cnt_d;
      drop_q    <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (if_valid && stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    // Flushed work = queue entries thrown away plus responses discarded.
    if (br) begin
      flush_cnt_d = flush_cnt_q + {30'd0, q_cnt_q} + {31'd0, rsp};
    end else if (rsp && (drop_q != 2'd0)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with queue-based reference model

module tb_if_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] br_target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  logic        stray;
  logic        mem_rv;
  logic [31:0] mem_rd;
  int          lat;
  int          cyc = 0;

  always #5 clk = ~clk;

  assign im_rvalid = mem_rv | stray;
  assign im_rdata  = stray ? 32'hDEAD_BEEF : mem_rd;

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br        (br),
    .br_target (br_target),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_gnt    (im_gnt),
    .im_rvalid (im_rvalid),
    .im_rdata  (im_rdata),
    .if_valid  (if_valid),
    .if_pc     (if_pc),
    .if_inst   (if_inst)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory: in-order responses, each 'lat' cycles after its grant.
  logic        iss_s;
  logic [31:0] addr_s;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  always @(negedge clk) begin
    iss_s  = (im_req === 1'b1) && (im_gnt === 1'b1);
    addr_s = im_addr;
  end

  always @(posedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (iss_s) begin
      mq_addr.push_back(addr_s);
      mq_due.push_back(cyc + lat - 1);
    end
    #1;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      mem_rv = 1'b1;
      mem_rd = mem_data(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      mem_rv = 1'b0;
      mem_rd = 32'd0;
    end
  end

  // Reference model: lists of in-flight addresses and presented instructions.
  logic [31:0] m_pc;
  logic [31:0] m_tags  [$];
  logic [31:0] m_qpc   [$];
  logic [31:0] m_qinst [$];
  int          m_drop;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;
  bit          started = 0;

  function automatic bit m_req();
    return (rst === 1'b0) && (br === 1'b0) && ((m_tags.size() + m_qpc.size()) < 2);
  endfunction

  always @(posedge clk) begin : model
    bit          rsp;
    bit          req;
    bit          valid;
    logic [31:0] rtag;
    req   = m_req();
    valid = (m_qpc.size() > 0);
    if (rst === 1'b1) begin
      started = 1;
      m_pc    = RPC;
      m_tags.delete();
      m_qpc.delete();
      m_qinst.delete();
      m_drop  = 0;
      m_scnt  = 32'd0;
      m_fcnt  = 32'd0;
    end else begin
      if (valid && stall === 1'b1) m_scnt = m_scnt + 32'd1;
      rsp  = (im_rvalid === 1'b1) && (m_tags.size() > 0);
      rtag = 32'd0;
      if (rsp) rtag = m_tags.pop_front();
      if (br === 1'b1) begin
        m_fcnt = m_fcnt + 32'(m_qpc.size()) + (rsp ? 32'd1 : 32'd0);
        m_qpc.delete();
        m_qinst.delete();
        m_drop = m_tags.size();
        m_pc   = br_target;
      end else begin
        if (valid && stall === 1'b0) begin
          void'(m_qpc.pop_front());
          void'(m_qinst.pop_front());
        end
        if (rsp) begin
          if (m_drop > 0) begin
            m_drop--;
            m_fcnt = m_fcnt + 32'd1;
          end else begin
            m_qpc.push_back(rtag);
            m_qinst.push_back(im_rdata);
          end
        end
        if (req && im_gnt === 1'b1) begin
          m_tags.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  logic [31:0] acc_log [$];

  always @(negedge clk) begin
    if (started) begin
      chk("im_req",   {31'd0, im_req},   {31'd0, m_req()});
      chk("im_addr",  im_addr,           m_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_qpc.size() > 0});
      chk("if_pc",    if_pc,             (m_qpc.size() > 0) ? m_qpc[0] : 32'd0);
      chk("if_inst",  if_inst,           (m_qinst.size() > 0) ? m_qinst[0] : 32'd0);
`ifdef FETCH_PERF_EN
      chk("stall_cnt", stall_cnt, m_scnt);
      chk("flush_cnt", flush_cnt, m_fcnt);
`endif
      if (if_valid === 1'b1 && stall === 1'b0 && br === 1'b0 && rst === 1'b0)
        acc_log.push_back(if_pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input int n, input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_qpc.size() >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (if_valid === 1'b1) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  logic [31:0] exp_seq [4];
  logic [31:0] spat;
  logic [31:0] gpat;

  initial begin
    rst = 1'b1; stall = 1'b0; br = 1'b0; br_target = 32'd0;
    im_gnt = 1'b1; stray = 1'b0; lat = 1;
    exp_seq[0] = 32'h100; exp_seq[1] = 32'h104; exp_seq[2] = 32'h108; exp_seq[3] = 32'h10C;
    tick(); tick();
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc",    if_pc,   32'd0);
    chk("rst_if_inst",  if_inst, 32'd0);
    chk("rst_im_req",   {31'd0, im_req}, 32'd0);
    chk("rst_im_addr",  im_addr, 32'h100);

    // Fill from reset; a stray response with nothing outstanding is ignored.
    tick(); rst = 1'b0; stray = 1'b1; #1;
    chk("c1_im_req",  {31'd0, im_req}, 32'd1);
    chk("c1_im_addr", im_addr, 32'h100);
    tick(); stray = 1'b0; #1;
    chk("c2_if_valid", {31'd0, if_valid}, 32'd0);
    chk("c2_im_addr",  im_addr, 32'h104);
    tick(); #1;
    chk("c3_if_pc",   if_pc,   32'h100);
    chk("c3_if_inst", if_inst, mem_data(32'h100));
    chk("c3_im_req",  {31'd0, im_req}, 32'd0);

    // Stall three cycles while 0x104 is presented.
    tick(); stall = 1'b1; #1;
    chk("c4_if_pc", if_pc, 32'h104);
    tick(); tick(); #1;
    chk("stall_if_pc",    if_pc, 32'h104);
    chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
    chk("stall_im_req",   {31'd0, im_req}, 32'd0);
    tick(); stall = 1'b0; #1;
    chk("release_if_pc", if_pc, 32'h104);
    for (int i = 0; i < 20 && acc_log.size() < 4; i++) tick();
    chk("acc_count", acc_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("acc_seq", (acc_log.size() > i) ? acc_log[i] : 32'hFFFF_FFFF, exp_seq[i]);

    // Redirect with two requests outstanding.
    lat = 4;
    begin
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
        if (m_tags.size() == 2) begin ok = 1; break; end
        tick();
      end
      chk("two_outstanding", {31'd0, ok}, 32'd1);
    end
    br = 1'b1; br_target = 32'h400; #1;
    chk("br_no_req", {31'd0, im_req}, 32'd0);
    tick(); br = 1'b0; #1;
    chk("br_if_valid", {31'd0, if_valid}, 32'd0);
    wait_valid("br_refill");
    chk("br_first_pc", if_pc, 32'h400);

    // Redirect together with stall: flush wins.
    lat = 1; stall = 1'b1;
    wait_q(2, "fill_before_br_stall");
    br = 1'b1; br_target = 32'h800;
    tick(); br = 1'b0; #1;
    chk("brstall_if_valid", {31'd0, if_valid}, 32'd0);
    stall = 1'b0;
    wait_valid("brstall_refill");
    chk("brstall_first_pc",   if_pc,   32'h800);
    chk("brstall_first_inst", if_inst, mem_data(32'h800));

    // PC wrap.
    br = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(); br = 1'b0; #1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        if (im_req === 1'b1) begin ok = 1; break; end
        tick();
      end
      chk("wrap_req_seen", {31'd0, ok}, 32'd1);
    end
    chk("wrap_pre_addr", im_addr, 32'hFFFF_FFFC);
    tick(); #1;
    chk("wrap_addr", im_addr, 32'h0000_0000);
    wait_valid("wrap_valid");
    chk("wrap_first_pc", if_pc, 32'hFFFF_FFFC);

    // Mixed stall / grant / latency traffic with a mid-stream redirect.
    spat = 32'b0010_0110_0000_1100_0111_0000_0100_1000;
    gpat = 32'b1101_1111_0111_1011_1110_1111_1010_1111;
    for (int i = 0; i < 96; i++) begin
      tick();
      stall  = spat[i % 32];
      im_gnt = gpat[i % 32];
      lat    = 1 + (i % 3);
      br     = (i == 40 || i == 41 || i == 70);
      br_target = 32'h2000 + 32'(i * 16);
    end
    tick(); stall = 1'b0; im_gnt = 1'b1; br = 1'b0; lat = 1;

    // Reset mid-stream with a full queue; reset overrides br and stall.
    stall = 1'b1;
    wait_q(2, "fill_before_rst");
    rst = 1'b1; br = 1'b1; br_target = 32'h7770;
    tick(); rst = 1'b0; br = 1'b0; stall = 1'b0; #1;
    chk("mrst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("mrst_if_pc",    if_pc,   32'd0);
    chk("mrst_if_inst",  if_inst, 32'd0);
    chk("mrst_im_addr",  im_addr, 32'h100);
`ifdef FETCH_PERF_EN
    chk("mrst_stall_cnt", stall_cnt, 32'd0);
    chk("mrst_flush_cnt", flush_cnt, 32'd0);
`endif
    repeat (8) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
